// File: rtl/decrypt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_pkg
// Description : Shared definitions for the stream decrypter. It holds the
//               controller state encoding, the keystream mode constants, the
//               default Galois LFSR taps and the default key word.
// Revision    : 1.0 - initial release
// ============================================================================
package decrypt_pkg;

    // Controller states; the width is explicit so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Keystream selection
    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_LFSR   = 1'b1;

    // Default 8-bit Galois feedback taps and default key word
    localparam logic [7:0] DEFAULT_LFSR_POLY = 8'hB8;
    localparam logic [7:0] DEFAULT_KEY       = 8'hB3;

endpackage
`default_nettype wire

// File: rtl/keystream_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : keystream_lfsr
// Description : Keystream generator. In static mode it holds the key. In
//               LFSR mode it holds a Galois LFSR that steps once per advance.
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   load    - capture seed and mode (job start)
//   seed    - key / LFSR seed
//   advance - step the LFSR (one returned word consumed)
//   mode    - MODE_STATIC or MODE_LFSR, sampled on load
//   ks      - current keystream word
// Revision    : 1.0 - initial release
// ============================================================================
module keystream_lfsr
    import decrypt_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_POLY = DEFAULT_LFSR_POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    input  logic              mode,
    output logic [DATA_W-1:0] ks
);

    logic              r_mode;
    logic [DATA_W-1:0] r_state;
    logic [DATA_W-1:0] w_seed;
    logic [DATA_W-1:0] w_next;

    always_comb begin
        // An all-zero Galois LFSR never leaves zero, so seed it with all-ones.
        w_seed = seed;
        if (mode == MODE_LFSR && seed == '0) begin
            w_seed = '1;
        end
        w_next = (r_state >> 1) ^ (r_state[0] ? LFSR_POLY : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_STATIC;
            r_state <= '0;
        end else if (load) begin
            r_mode  <= mode;
            r_state <= w_seed;
        end else if (advance && r_mode == MODE_LFSR) begin
            r_state <= w_next;
        end
    end

    assign ks = r_state;

endmodule
`default_nettype wire

// File: rtl/stream_decrypter.sv
`default_nettype none
// ============================================================================
// Module      : stream_decrypter
// Description : Reads LENGTH words from a source buffer, XORs each word with
//               a static or LFSR keystream and writes the result to a
//               destination buffer. The source RAM may have a read latency of
//               RD_LAT cycles.
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - job request (honoured only when idle)
//   mode, key          - keystream selection and key / seed
//   length             - word count (0 allowed)
//   src_base, dst_base - first read / write address
//   encrypted_data     - source RAM data, RD_LAT cycles after rd_en
//   rd_en, read_addr   - source read strobe and address
//   wr_en, write_addr, decrypted_data - destination write port
//   busy, done         - job in progress / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module stream_decrypter
    import decrypt_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 15,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] LFSR_POLY = DEFAULT_LFSR_POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] key,
    input  logic [ADDR_W-1:0] length,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DATA_W-1:0] encrypted_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] decrypted_data,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_remaining;   // reads still to issue after the current one
    logic [ADDR_W-1:0] r_wr_ptr;      // address for the next returned word
    logic [RD_LAT-1:0] r_vld;         // tracks outstanding reads through the RAM
    logic              w_accept;
    logic              w_ret;
    logic [DATA_W-1:0] w_ks;

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_ret    = r_vld[RD_LAT-1];

    // Controller: read issue, completion and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            rd_en       <= 1'b0;
            read_addr   <= '0;
            r_remaining <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length == '0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            rd_en       <= 1'b1;
                            read_addr   <= src_base;
                            r_remaining <= length - ADDR_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_remaining == '0) begin
                        rd_en   <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        read_addr   <= read_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // With no read in flight, the output register holds at most
                    // the final write, which retires on this same edge.
                    if (r_vld == '0) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Data path: read-valid pipeline and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld          <= '0;
            r_wr_ptr       <= '0;
            wr_en          <= 1'b0;
            write_addr     <= '0;
            decrypted_data <= '0;
        end else begin
            r_vld[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            wr_en <= w_ret;
            if (w_accept) begin
                r_wr_ptr <= dst_base;
            end else if (w_ret) begin
                r_wr_ptr       <= r_wr_ptr + ADDR_W'(1);
                write_addr     <= r_wr_ptr;
                decrypted_data <= encrypted_data ^ w_ks;
            end
        end
    end

    // The LFSR steps only on returned words, keeping it word-aligned.
    keystream_lfsr #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (LFSR_POLY)
    ) u_keystream (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_accept),
        .seed    (key),
        .advance (w_ret),
        .mode    (mode),
        .ks      (w_ks)
    );

endmodule
`default_nettype wire

// File: doc/stream_decrypter.md
Name: stream_decrypter

Overview:
- Parametrised, handshake-driven successor to the free-running XOR decrypter in the VGA image path.
- On a start pulse it reads LENGTH words from a source frame buffer starting at a programmable base address.
- Each word is XORed with a keystream, and the result is written to a destination buffer at its own base address.
- Mode 0 uses a static key word; mode 1 uses an LFSR keystream seeded by the key.
- Sits between the encrypted image RAM and the VGA display RAM; supports block-RAM read latencies of 1 or more.

Parameters:
- DATA_W, 8, data/key word width in bits.
- ADDR_W, 15, address and length width.
- RD_LAT, 1, source memory read latency in cycles (>=1).
- LFSR_POLY, 8'hB8, Galois feedback taps (DATA_W bits).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle job request; honoured only in IDLE.
- mode  in  1  0 = static key, 1 = LFSR keystream.
- key  in  DATA_W  key / LFSR seed, latched at start.
- length  in  ADDR_W  number of words to process; 0 is legal.
- src_base  in  ADDR_W  first read address.
- dst_base  in  ADDR_W  first write address.
- encrypted_data  in  DATA_W  source RAM data, valid RD_LAT cycles after rd_en.
- rd_en  out  1  source read strobe.
- read_addr  out  ADDR_W  source address.
- wr_en  out  1  destination write strobe.
- write_addr  out  ADDR_W  destination address.
- decrypted_data  out  DATA_W  destination data.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rd_en, wr_en, busy, done = 0; read_addr, write_addr, decrypted_data = 0; counters, read-valid pipeline and LFSR cleared.
- Reset mid-job: aborts immediately. No further wr_en. After release, the block waits in IDLE for a fresh start.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start (call this cycle 0), latch mode, key, length and the two bases.
  - length==0 -> go to DONE.
  - otherwise -> go to ISSUE.
- ISSUE: rd_en=1 with read_addr=src_base+i for i=0..length-1, one read per cycle, in cycles 1..length. After the last issue -> DRAIN.
- DRAIN: wait until the read-valid pipeline (RD_LAT deep) and the output register are empty -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy: 1 in every non-IDLE state, including the done cycle.
- Data path:
  - A read issued in cycle k returns in cycle k+RD_LAT.
  - The registered output gives wr_en=1 in cycle k+RD_LAT+1, with write_addr=dst_base+i and decrypted_data=encrypted_data^ks_i.
- Mode 0: ks_i = key for all i.
- Mode 1 (LFSR):
  - ks_0 = key, or all-ones if key==0 (a zero seed would lock the LFSR).
  - ks_{i+1} = (ks_i>>1) ^ (ks_i[0] ? LFSR_POLY : 0).
  - The LFSR advances only on a returned valid word, so the keystream stays word-aligned for any RD_LAT.
- Address arithmetic: all address arithmetic is modulo 2^ADDR_W; wrap past all-ones to 0 silently.
- start while busy: ignored. Latched job parameters do not change.
- start in the same cycle as done: ignored; the block is not in IDLE.
- Writes are never back-to-back-overlapping: exactly length wr_en pulses per job.
- Total job latency: done asserted in cycle length+RD_LAT+2 (length>0); cycle 1 when length==0.

Decomposition:
- Package decrypt_pkg holds:
  - FSM state encoding (IDLE/ISSUE/DRAIN/DONE).
  - Mode constants MODE_STATIC=0 and MODE_LFSR=1.
  - Default LFSR_POLY.
  - Default key 8'hB3 used by the top level.
- One sub-module, keystream_lfsr:
  - Ports: clk, rst_n, load, seed, advance, mode, ks.
  - Handles the seed-zero substitution and the static/LFSR selection.
- FSM, address counters and the valid shift register stay in stream_decrypter.

Test Plan:
- Static key: mode=0, key=8'hB3, length=4, src_base=0, dst_base=0x100, every word 8'hA5.
  - Expect 4 wr_en pulses, write_addr 0x100..0x103, decrypted_data=8'h16 each.
  - done in cycle 7 (RD_LAT=1).
- LFSR: mode=1, key=8'h01, LFSR_POLY=8'hB8, source all zeros, length=4.
  - Expect decrypted_data 8'h01, 8'hB8, 8'h5C, 8'h2E.
  - Repeat with key=0: first word must be 8'hFF.
- Wrap and latency: src_base=0x7FFE, dst_base=0x7FFF, length=3, RD_LAT=3.
  - Expect read_addr 7FFE, 7FFF, 0000 and write_addr 7FFF, 0000, 0001.
  - Expect first wr_en 4 cycles after first rd_en and done in cycle 8.
- Zero length and ignored start:
  - length=0 -> done in cycle 1 with no rd_en/wr_en.
  - A second start pulse during ISSUE of a length=8 job changes nothing: 8 writes, one done.
- Reset mid-job: assert rst_n=0 during DRAIN.
  - All outputs go 0 asynchronously and no further wr_en appears.
  - A new length=2 job after release completes normally.
